lif_array: RTL and testbench

Parametrised array of N leaky integrate-and-fire neurons that updates all channels on a common `step` strobe. Each channel has configurable membrane width, shift-based leak, a runtime threshold, a refractory period and a saturating spike counter. It replaces hand-instantiated fixed 4-bit neurons and is the building block for layered spiking networks inside the top-level tile wrapper.

---
 rtl/lif_pkg.sv | 27 ++
 rtl/lif_cell.sv | 69 ++++++
 rtl/lif_array.sv | 58 +++++
 tb/tb_lif_array.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

    localparam int REF_W       = 4;
    localparam int N_MIN       = 1;
    localparam int N_MAX       = 16;
    localparam int W_MIN       = 2;
    localparam int W_MAX       = 12;
    localparam int REFRAC_MAX  = (1 << REF_W) - 1;
    localparam int COUNT_W_MIN = 1;
    localparam int SUM_W       = W_MAX + 1;

    // Unsigned add clamped to 2^w-1; operands are zero-extended to SUM_W.
    function automatic logic [SUM_W-1:0] sat_add(
        input logic [SUM_W-1:0] a,
        input logic [SUM_W-1:0] b,
        input int unsigned      w
    );
        logic [SUM_W:0]   s;
        logic [SUM_W-1:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = SUM_W'(1) << w;
        lim = lim - SUM_W'(1);
        return (s > {1'b0, lim}) ? lim : s[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire channel: membrane, refractory timer and
// saturating spike counter, advanced once per step strobe.
module lif_cell
    import lif_pkg::*;
#(
    parameter int W          = 4,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               step,
    input  logic [W-1:0]       current,
    input  logic [W-1:0]       threshold,
    input  logic               cnt_clear,
    output logic [W-1:0]       state,
    output logic               spk,
    output logic [COUNT_W-1:0] spk_count
);

    localparam logic [REF_W-1:0] REF_INIT = REF_W'(REFRAC);

    logic [W-1:0]       r_mem;
    logic [REF_W-1:0]   r_ref;
    logic [COUNT_W-1:0] r_cnt;
    logic               r_spk;

    logic [W-1:0]     w_decay;
    logic [SUM_W-1:0] w_sum;
    logic             w_fire;

    assign w_decay = r_mem - (r_mem >> LEAK_SHIFT);
    assign w_sum   = sat_add(SUM_W'(w_decay), SUM_W'(current), W);
    assign w_fire  = (w_sum >= SUM_W'(threshold));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
            r_ref <= '0;
            r_cnt <= '0;
            r_spk <= 1'b0;
        end else begin
            r_spk <= 1'b0;
            if (step) begin
                if (r_ref != '0) begin
                    r_mem <= '0;
                    r_ref <= r_ref - REF_W'(1);
                end else if (w_fire) begin
                    r_mem <= '0;
                    r_ref <= REF_INIT;
                    r_spk <= 1'b1;
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + COUNT_W'(1);
                end else begin
                    r_mem <= w_sum[W-1:0];
                end
            end
            // Clear wins over a same-cycle increment; the spike still pulses.
            if (cnt_clear)
                r_cnt <= '0;
        end
    end

    assign state     = r_mem;
    assign spk       = r_spk;
    assign spk_count = r_cnt;

endmodule

// File: rtl/lif_array.sv
// Array of N independent LIF channels sharing step and threshold; per-channel
// buses are packed with channel i at [i*width +: width].
module lif_array
    import lif_pkg::*;
#(
    parameter int N          = 2,
    parameter int W          = 4,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int COUNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step,
    input  logic [N*W-1:0]       current,
    input  logic [W-1:0]         threshold,
    input  logic                 cnt_clear,
    output logic [N*W-1:0]       state,
    output logic [N-1:0]         spk,
    output logic [N*COUNT_W-1:0] spk_count
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("lif_array: N out of range");
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("lif_array: W out of range");
    end
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > W) begin : g_bad_leak
        $error("lif_array: LEAK_SHIFT out of range");
    end
    if (REFRAC < 0 || REFRAC > REFRAC_MAX) begin : g_bad_refrac
        $error("lif_array: REFRAC does not fit the refractory counter");
    end
    if (COUNT_W < COUNT_W_MIN) begin : g_bad_count
        $error("lif_array: COUNT_W out of range");
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        lif_cell #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC),
            .COUNT_W    (COUNT_W)
        ) u_cell (
            .clk       (clk),
            .reset_n   (reset_n),
            .step      (step),
            .current   (current[i*W +: W]),
            .threshold (threshold),
            .cnt_clear (cnt_clear),
            .state     (state[i*W +: W]),
            .spk       (spk[i]),
            .spk_count (spk_count[i*COUNT_W +: COUNT_W])
        );
    end

endmodule

// File: tb/tb_lif_array.sv
// Directed table-driven bench for lif_array (N=2, W=4, LEAK_SHIFT=1, REFRAC=2,
// COUNT_W=3) with a hand-written async-reset-during-refractory sequence.
module tb_lif_array;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       step;
    logic [7:0] current;
    logic [3:0] threshold;
    logic       cnt_clear;
    logic [7:0] state;
    logic [1:0] spk;
    logic [5:0] spk_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       stp;
        logic       clr;
        logic [3:0] c0;
        logic [3:0] c1;
        logic [3:0] thr;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] sp;
        logic [2:0] n0;
        logic [2:0] n1;
    } vec_t;

    vec_t tbl[$];

    lif_array #(
        .N          (2),
        .W          (4),
        .LEAK_SHIFT (1),
        .REFRAC     (2),
        .COUNT_W    (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .step      (step),
        .current   (current),
        .threshold (threshold),
        .cnt_clear (cnt_clear),
        .state     (state),
        .spk       (spk),
        .spk_count (spk_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic stp, input logic clr, input logic [3:0] c0,
                       input logic [3:0] c1, input logic [3:0] thr,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] sp, input logic [2:0] n0,
                       input logic [2:0] n1);
        vec_t v;
        v = '{stp, clr, c0, c1, thr, s0, s1, sp, n0, n1};
        tbl.push_back(v);
    endtask

    initial begin
        //   stp clr c0  c1  thr  s0  s1  spk    n0 n1
        // sub-threshold on ch0, fire/refractory on ch1
        add(1, 0, 3,  5,  8,   3,  5, 2'b00, 0, 0);
        add(1, 0, 3,  5,  8,   5,  0, 2'b10, 0, 1);
        add(1, 0, 3,  5,  8,   6,  0, 2'b00, 0, 1);
        add(1, 0, 3,  5,  8,   6,  0, 2'b00, 0, 1);
        add(1, 0, 3,  5,  8,   6,  5, 2'b00, 0, 1);
        add(1, 0, 3,  5,  8,   6,  0, 2'b10, 0, 2);
        // gapped step: refractory counts steps, not clocks
        add(0, 0, 5,  5,  8,   6,  0, 2'b00, 0, 2);
        add(1, 0, 5,  5,  8,   0,  0, 2'b01, 1, 2);
        add(0, 0, 5,  5,  8,   0,  0, 2'b00, 1, 2);
        add(1, 0, 5,  5,  8,   0,  0, 2'b00, 1, 2);
        add(0, 0, 5,  5,  8,   0,  0, 2'b00, 1, 2);
        add(1, 0, 5,  5,  8,   0,  5, 2'b00, 1, 2);
        add(1, 0, 5,  5,  8,   5,  0, 2'b10, 1, 3);
        // leak-only decay on ch0, saturating integrate on ch1
        add(1, 0, 0, 14, 15,   3,  0, 2'b00, 1, 3);
        add(1, 0, 0, 14, 15,   2,  0, 2'b00, 1, 3);
        add(1, 0, 0, 14, 15,   1, 14, 2'b00, 1, 3);
        add(1, 0, 0, 15, 15,   1,  0, 2'b10, 1, 4);
        // threshold 0: fire on every non-refractory step, counters saturate
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 2, 4);
        add(1, 0, 0,  0,  0,   0,  0, 2'b00, 2, 4);
        add(1, 0, 0,  0,  0,   0,  0, 2'b10, 2, 5);
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 3, 5);
        add(1, 0, 0,  0,  0,   0,  0, 2'b00, 3, 5);
        add(1, 0, 0,  0,  0,   0,  0, 2'b10, 3, 6);
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 4, 6);
        add(1, 0, 0,  0,  0,   0,  0, 2'b00, 4, 6);
        add(1, 0, 0,  0,  0,   0,  0, 2'b10, 4, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 5, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b00, 5, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b10, 5, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 6, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b00, 6, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b10, 6, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 7, 7);
        add(1, 0, 0,  0,  0,   0,  0, 2'b00, 7, 7);
        // clear on a spike cycle: counts drop to 0, spike still pulses
        add(1, 1, 0,  0,  0,   0,  0, 2'b10, 0, 0);
        add(1, 0, 0,  0,  0,   0,  0, 2'b01, 1, 0);

        reset_n   = 1'b0;
        step      = 1'b0;
        current   = '0;
        threshold = 4'd8;
        cnt_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 32'(state), 32'd0);
        check("reset_spk",   0, 32'(spk), 32'd0);
        check("reset_count", 0, 32'(spk_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            step      = tbl[i].stp;
            cnt_clear = tbl[i].clr;
            current   = {tbl[i].c1, tbl[i].c0};
            threshold = tbl[i].thr;
            @(posedge clk);
            #1;
            check("state", i + 1, 32'(state), 32'({tbl[i].s1, tbl[i].s0}));
            check("spk",   i + 1, 32'(spk), 32'(tbl[i].sp));
            check("count", i + 1, 32'(spk_count), 32'({tbl[i].n1, tbl[i].n0}));
        end

        // Async reset one cycle after a spike, while channel 0 is refractory
        @(negedge clk);
        step = 1'b0; cnt_clear = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step = 1'b1; threshold = 4'd8; current = {4'd0, 4'd5};
        @(posedge clk); #1;
        check("ar_integrate", 0, 32'(state), 32'h05);
        @(posedge clk); #1;
        check("ar_spike_spk",   0, 32'(spk), 32'b01);
        check("ar_spike_state", 0, 32'(state), 32'h00);
        @(posedge clk); #1;
        check("ar_refrac_spk",   0, 32'(spk), 32'b00);
        check("ar_refrac_count", 0, 32'(spk_count), 32'o01);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_async_state", 0, 32'(state), 32'd0);
        check("ar_async_spk",   0, 32'(spk), 32'd0);
        check("ar_async_count", 0, 32'(spk_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ar_resume_state", 0, 32'(state), 32'h05);
        check("ar_resume_spk",   0, 32'(spk), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
